// File: rtl/comparator_1bit_pkg.sv
// Shared result encoding and parameter defaults for comparator_1bit.
package comparator_1bit_pkg;

  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/comparator_1bit.sv
// 1-bit magnitude comparator: combinational one-hot result, registered copy,
// change pulse, and optional per-outcome tallies (COMPARATOR_1BIT_STATS_EN).
module comparator_1bit
  import comparator_1bit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             en,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             A_gt_B,
  output logic [2:0]       res_q,
  output logic             res_chg
`ifdef COMPARATOR_1BIT_STATS_EN
  ,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt
`endif
);

  // Elaboration-time guard on the counter width.
  if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_w_check
    $error("comparator_1bit: CNT_W must be in 1..32");
  end

  logic [2:0] res_comb;
  logic [2:0] res_q_reg;
  logic       res_chg_reg;

  assign A_lt_B   = ~A &  B;
  assign A_eq_B   = ~(A ^ B);
  assign A_gt_B   =  A & ~B;
  assign res_comb = {A_lt_B, A_eq_B, A_gt_B};

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q_reg   <= RES_EQ;
      res_chg_reg <= 1'b0;
    end else if (en) begin
      res_q_reg   <= res_comb;
      res_chg_reg <= (res_comb != res_q_reg);
    end else begin
      res_chg_reg <= 1'b0;
    end
  end

  assign res_q   = res_q_reg;
  assign res_chg = res_chg_reg;

`ifdef COMPARATOR_1BIT_STATS_EN
  // Bit order of inc/cnt_arr follows res_comb: [2]=lt, [1]=eq, [0]=gt.
  logic [2:0]       inc;
  logic [CNT_W-1:0] cnt_arr [3];

  assign inc = res_comb & {3{en}};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(inc[gi]),
      .cnt(cnt_arr[gi])
    );
  end

  assign lt_cnt = cnt_arr[2];
  assign eq_cnt = cnt_arr[1];
  assign gt_cnt = cnt_arr[0];
`endif

endmodule

// File: tb/tb_comparator_1bit.sv
// Scoreboard bench for comparator_1bit (CNT_W=4); counter checks only when
// COMPARATOR_1BIT_STATS_EN is defined.
module tb_comparator_1bit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          en = 1'b0;
  logic          lt, eq, gt;
  logic [2:0]    res_q;
  logic          res_chg;
  logic [CW-1:0] lt_cnt, eq_cnt, gt_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]    res;
    logic          chg;
    logic [CW-1:0] lt;
    logic [CW-1:0] eq;
    logic [CW-1:0] gt;
  } exp_t;

  exp_t sb_q[$];

  logic [2:0]    m_res = 3'b010;
  logic          m_chg = 1'b0;
  logic [CW-1:0] m_lt = '0, m_eq = '0, m_gt = '0;

  comparator_1bit #(.CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (a),
    .B      (b),
    .en     (en),
    .A_lt_B (lt),
    .A_eq_B (eq),
    .A_gt_B (gt),
    .res_q  (res_q),
    .res_chg(res_chg)
`ifdef COMPARATOR_1BIT_STATS_EN
    ,
    .lt_cnt (lt_cnt),
    .eq_cnt (eq_cnt),
    .gt_cnt (gt_cnt)
`endif
  );

`ifndef COMPARATOR_1BIT_STATS_EN
  assign lt_cnt = '0;
  assign eq_cnt = '0;
  assign gt_cnt = '0;
`endif

  always #5 clk = clk_run ? ~clk : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic x, input logic y);
    if (int'(x) < int'(y))      return 3'b100;
    else if (int'(x) > int'(y)) return 3'b001;
    else                        return 3'b010;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (int'(v) == (1 << CW) - 1) ? v : v + 1'b1;
  endfunction

  // Drive one cycle of stimulus, push the model's expectation, then pop and
  // compare against the DUT just after the sampling edge.
  task automatic step(input logic sa, input logic sb, input logic sen, input logic srst);
    logic [2:0] nxt;
    exp_t e;
    a = sa; b = sb; en = sen; rst = srst;
    if (srst) begin
      m_res = 3'b010; m_chg = 1'b0; m_lt = '0; m_eq = '0; m_gt = '0;
    end else if (sen) begin
      nxt = ref_cmp(sa, sb);
      m_chg = (nxt != m_res);
      m_res = nxt;
      if (nxt == 3'b100) m_lt = sat_inc(m_lt);
      if (nxt == 3'b010) m_eq = sat_inc(m_eq);
      if (nxt == 3'b001) m_gt = sat_inc(m_gt);
    end else begin
      m_chg = 1'b0;
    end
    sb_q.push_back('{m_res, m_chg, m_lt, m_eq, m_gt});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      $display("[TB] rst=%0b en=%0b A=%0b B=%0b res_q=%03b chg=%0b cnt=%0d/%0d/%0d",
               srst, sen, sa, sb, res_q, res_chg, lt_cnt, eq_cnt, gt_cnt);
      chk("res_q", 32'(res_q), 32'(e.res));
      chk("res_chg", 32'(res_chg), 32'(e.chg));
`ifdef COMPARATOR_1BIT_STATS_EN
      chk("lt_cnt", 32'(lt_cnt), 32'(e.lt));
      chk("eq_cnt", 32'(eq_cnt), 32'(e.eq));
      chk("gt_cnt", 32'(gt_cnt), 32'(e.gt));
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pats;
    logic [2:0] want [4];
    want[0] = 3'b010; want[1] = 3'b100; want[2] = 3'b001; want[3] = 3'b010;

    // Combinational sweep with clock idle and reset deasserted.
    for (int i = 0; i < 4; i++) begin
      pats = 4'(i);
      a = pats[1]; b = pats[0];
      #20;
      $display("[TB] comb A=%0b B=%0b lt/eq/gt=%0b%0b%0b", a, b, lt, eq, gt);
      chk("comb", 32'({lt, eq, gt}), 32'(want[i]));
      chk("onehot", 32'($countones({lt, eq, gt})), 32'(1));
    end

    clk_run = 1'b1;
    @(posedge clk);
    #1;

    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) step(1'(i), 1'(i >> 1) ^ 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           ($urandom_range(15) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_1bit.md
# comparator_1bit

Single-bit magnitude comparator with a combinational one-hot result (A<B, A==B, A>B). An optional clocked block adds a registered copy of the result and a change pulse. When the statistics feature is compiled in, it also keeps saturating per-outcome tally counters. The block is a leaf primitive, used directly by control logic and as the building block for wider comparators.

## Interface
Parameters:
- CNT_W, default 8: width of each statistics counter (1..32).

Ports:
- clk  input  1  system clock. One clock domain only.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- A  input  1  first operand.
- B  input  1  second operand.
- en  input  1  sample enable for the clocked path. Active-high.
- A_lt_B  output  1  combinational; 1 iff A=0 and B=1.
- A_eq_B  output  1  combinational; 1 iff A==B.
- A_gt_B  output  1  combinational; 1 iff A=1 and B=0.
- res_q  output  3  registered result {lt,eq,gt}.
- res_chg  output  1  one-cycle pulse when res_q changes on a sample.
- lt_cnt, eq_cnt, gt_cnt  output  CNT_W each  tally counters. Present only with COMPARATOR_1BIT_STATS_EN.

## Operation
- Combinational outputs are exactly one-hot for every known input combination:
  - A=0, B=0 → eq.
  - A=0, B=1 → lt.
  - A=1, B=0 → gt.
  - A=1, B=1 → eq.
- The combinational outputs do not depend on clk, rst or en. They must be correct with clk idle and rst unasserted.
- Clocked path, on a rising clk with en=1:
  - res_q ← {A_lt_B, A_eq_B, A_gt_B}.
  - res_chg ← 1 if the new value differs from the old res_q, else 0.
  - The counter for the current outcome increments by 1.
- With en=0: res_q and the counters hold, and res_chg ← 0.
- Counters saturate at 2^CNT_W−1 and never wrap. A saturated counter holds while the other counters keep counting.

## Timing
- Combinational outputs: zero-cycle latency, purely combinational from A and B.
- res_q, res_chg and the counters: 1-cycle latency from the sampling edge.
- Reset values: res_q = 3'b010 (eq), res_chg = 0, all counters = 0.
- rst has priority over en. If both are high on the same edge, reset values are loaded and no count occurs.
- The first sample after reset compares against the reset value res_q = eq. The case A=B therefore gives res_chg = 0.
- Reset in mid-operation clears all state on the next edge. Sampling resumes on the first edge with rst=0 and en=1.

## Configuration
- COMPARATOR_1BIT_STATS_EN defined:
  - lt_cnt, eq_cnt and gt_cnt ports and their logic exist.
  - Each counter is CNT_W bits and saturating.
- Not defined:
  - The counter ports are absent.
  - The combinational outputs and res_q/res_chg behave identically.
  - CNT_W is unused.

## Structure
- Shared package comparator_1bit_pkg holds:
  - the result encoding constants RES_LT=3'b100, RES_EQ=3'b010, RES_GT=3'b001;
  - the localparam default for CNT_W.
- One natural sub-module: sat_counter. It takes parameter W and ports clk, rst, inc and cnt, and is instantiated three times under the macro.

## Test plan
- Combinational sweep, clk idle: drive (A,B) = (0,0), (0,1), (1,0), (1,1), holding each for 20 ns.
  - Required outputs {lt,eq,gt}: 010, 100, 001, 010.
  - Outputs must be one-hot at every step.
- Reset: assert rst for 2 cycles with en=1 and A=1, B=0.
  - Required: res_q=010, res_chg=0, counters=0 throughout.
- Sampling and change pulse: release rst, then apply A=1, B=0 for 1 cycle, followed by A=1, B=1 for 1 cycle.
  - Required res_q: 001 then 010.
  - Required res_chg: 1 then 1.
- Enable gating: drive en=0 and toggle A/B for 5 cycles.
  - Required: res_q, res_chg=0 and the counters remain unchanged.
- Saturation (stats build, CNT_W=4): hold A=0, B=1 with en=1 for 20 cycles.
  - Required: lt_cnt=15 and holds; eq_cnt and gt_cnt are unchanged.
- Reset mid-count: assert rst for 1 cycle while counters are non-zero.
  - Required: all counters are 0 and res_q=010 on the next cycle.
